maze_palette_sequencer: RTL

//  Registered colour scheduler for the maze VGA pixel path. Owns the maze colour-cycling phase: prescaled phase

---
 rtl/maze_palette_sequencer_pkg.sv | 45 ++++
 rtl/maze_palette_sequencer_phase_timer.sv | 52 +++++
 rtl/maze_palette_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/maze_palette_sequencer_pkg.sv
// Shared types, encodings and palette lookup for the maze colour scheduler.
package maze_palette_sequencer_pkg;

  localparam int unsigned RGB_W      = 8;
  localparam int unsigned PHASE_W    = 3;
  localparam int unsigned N_PORTIONS = 6;

  localparam logic MODE_BLINK  = 1'b1;
  localparam logic MODE_ROTATE = 1'b0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef logic [RGB_W-1:0] rgb_t;

  // Colour of wall portion idx for the given mode and committed phase.
  // BLINK lights portion idx when phase[1:0] == idx mod 3 (phase 3 is all black);
  // ROTATE lights the primary colour on the matching portion, alternate elsewhere.
  function automatic rgb_t portion_colour(input logic [2:0]         idx,
                                          input logic               mode,
                                          input logic [PHASE_W-1:0] phase);
    rgb_t       c;
    rgb_t       a;
    logic [1:0] m3;
    c  = RGB_W'(0);
    a  = RGB_W'(0);
    m3 = 2'd0;
    case (idx)
      3'd0:    begin c = 8'h92; a = 8'h0B; m3 = 2'd0; end
      3'd1:    begin c = 8'hD8; a = 8'h92; m3 = 2'd1; end
      3'd2:    begin c = 8'hD1; a = 8'h26; m3 = 2'd2; end
      3'd3:    begin c = 8'h26; a = 8'hD8; m3 = 2'd0; end
      3'd4:    begin c = 8'hAB; a = 8'hD1; m3 = 2'd1; end
      3'd5:    begin c = 8'h0B; a = 8'hD1; m3 = 2'd2; end
      default: begin c = RGB_W'(0); a = RGB_W'(0); m3 = 2'd0; end
    endcase
    if (mode == MODE_BLINK) begin
      return (phase[1:0] == m3) ? c : RGB_W'(0);
    end
    return (phase == idx) ? c : a;
  endfunction

endpackage

// File: rtl/maze_palette_sequencer_phase_timer.sv
// maze_phase_timer: phase-step prescaler plus pending-advance flag.
//  clk, rst     clock, async active-low reset
//  run          1: prescaler counts 0..limit-1; 0: prescaler frozen, step sets pending
//  limit        cycles per phase step
//  clear        zero prescaler and pending (mode change)
//  ack          pending consumed by a phase commit this cycle
//  step         single-step request, honoured only while not running
//  pending_c    pending flag including a request raised this very cycle
module maze_phase_timer #(
  parameter int unsigned PRESC_W = 29
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [PRESC_W-1:0] limit,
  input  logic               clear,
  input  logic               ack,
  input  logic               step,
  output logic               pending_c
);

  logic [PRESC_W-1:0] presc_q;
  logic               pending_q;
  logic               terminal_c;
  logic               set_c;

  // Same-cycle requests are visible so a coincident frame_start can commit them.
  assign terminal_c = run && (presc_q == (limit - PRESC_W'(1)));
  assign set_c      = terminal_c || (!run && step);
  assign pending_c  = pending_q || set_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q   <= '0;
      pending_q <= 1'b0;
    end else if (clear) begin
      presc_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      if (run) begin
        presc_q <= terminal_c ? '0 : presc_q + PRESC_W'(1);
      end
      // Multiple requests before a commit collapse into one advance.
      if (ack) begin
        pending_q <= 1'b0;
      end else if (set_c) begin
        pending_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/maze_palette_sequencer.sv
// maze_palette_sequencer: colour-cycling phase scheduler and registered pixel mux
// between maze_and_ball and the VGA RGB pins.
//  clk, rst             clock, async active-low reset
//  mode                 1=BLINK (4 phases), 0=ROTATE (8 phases); takes effect at frame_start
//  hold, step           freeze auto-advance / single-step while frozen
//  frame_start          VS pulse; the only instant phase or mode changes commit
//  blank, maze_en, maze_en_portions, ball_en, ball_rgb   pixel source inputs
//  rgb                  registered {R3,G3,B2} pixel
//  phase, phase_tick    committed phase and its change pulse
module maze_palette_sequencer
  import maze_palette_sequencer_pkg::*;
#(
  parameter int unsigned STEP_BLINK  = 134217728,
  parameter int unsigned STEP_ROTATE = 268435456,
  parameter int unsigned PRESC_W     = 29
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  hold,
  input  logic                  step,
  input  logic                  frame_start,
  input  logic                  blank,
  input  logic                  maze_en,
  input  logic [N_PORTIONS-1:0] maze_en_portions,
  input  logic                  ball_en,
  input  logic [RGB_W-1:0]      ball_rgb,
  output logic [RGB_W-1:0]      rgb,
  output logic [PHASE_W-1:0]    phase,
  output logic                  phase_tick
);

  state_e               state_q;
  state_e               state_d;
  logic                 run_c;
  logic                 mode_q;
  logic [PHASE_W-1:0]   phase_q;
  logic                 tick_q;
  rgb_t                 rgb_q;
  logic                 pending_c;
  logic                 mode_chg_c;
  logic                 commit_c;
  logic [PRESC_W-1:0]   limit_c;
  logic [PHASE_W-1:0]   next_phase_c;
  rgb_t                 maze_rgb_c;
  rgb_t                 pix_c;

  // Mode change wins over a pending advance on the same frame_start.
  assign mode_chg_c   = frame_start && (mode != mode_q);
  assign commit_c     = frame_start && pending_c && !mode_chg_c;
  assign limit_c      = (mode_q == MODE_BLINK) ? PRESC_W'(STEP_BLINK) : PRESC_W'(STEP_ROTATE);
  assign next_phase_c = (mode_q == MODE_BLINK) ? {1'b0, phase_q[1:0] + 2'd1}
                                               : phase_q + PHASE_W'(1);

  maze_phase_timer #(
    .PRESC_W (PRESC_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (run_c),
    .limit     (limit_c),
    .clear     (mode_chg_c),
    .ack       (commit_c),
    .step      (step),
    .pending_c (pending_c)
  );

  // RUN/HOLD state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // RUN/HOLD next state and run enable.
  always_comb begin
    state_d = state_q;
    run_c   = 1'b0;
    case (state_q)
      ST_RUN: begin
        run_c = 1'b1;
        if (hold) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!hold) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Pixel mux; ascending scan lets the highest set portion win.
  always_comb begin
    maze_rgb_c = RGB_W'(0);
    for (int i = 0; i < N_PORTIONS; i++) begin
      if (maze_en_portions[i]) maze_rgb_c = portion_colour(3'(i), mode_q, phase_q);
    end
    pix_c = RGB_W'(0);
    if (blank)        pix_c = RGB_W'(0);
    else if (ball_en) pix_c = ball_rgb;
    else if (maze_en) pix_c = maze_rgb_c;
  end

  // Phase, mode and pixel registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= MODE_ROTATE;
      phase_q <= '0;
      tick_q  <= 1'b0;
      rgb_q   <= RGB_W'(0);
    end else begin
      rgb_q  <= pix_c;
      tick_q <= mode_chg_c || commit_c;
      if (mode_chg_c) begin
        mode_q  <= mode;
        phase_q <= '0;
      end else if (commit_c) begin
        phase_q <= next_phase_c;
      end
    end
  end

  assign rgb        = rgb_q;
  assign phase      = phase_q;
  assign phase_tick = tick_q;

endmodule
